// File: rtl/subtractor_32bit_pipe_if.sv
`timescale 1ns/1ps
// Operand/result handshake bundle for the pipelined subtractor.
// master = operand producer + result consumer, slave = the subtractor.
// Both directions use valid/ready; a transfer happens when both are high on a rising edge.
interface subtractor_32bit_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
endinterface

// File: rtl/subtractor_32bit_pipe.sv
`timescale 1ns/1ps
// Pipelined unsigned subtractor: diff = a - b mod 2^WIDTH, borrow = (a < b), one SLICE per stage.
// Latency: STAGES = WIDTH/SLICE cycles from accepted operands to out_valid; one result per cycle.
// Backpressure: the whole pipe advances only when the output is empty or being taken; in_ready = advance.
module subtractor_32bit_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  subtractor_32bit_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SLICE;

  if (WIDTH % SLICE != 0) begin : g_param_chk
    $error("subtractor_32bit_pipe: WIDTH must be an integer multiple of SLICE");
  end

  logic advance;
  logic out_vld;

  // Stall is global: nothing moves while a finished result waits for the consumer.
  assign advance      = bus.out_ready | ~out_vld;
  assign bus.in_ready = advance;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    localparam int LOW  = (k + 1) * SLICE;   // diff bits resolved once this stage has loaded
    localparam int SRC  = WIDTH - k * SLICE; // operand bits still unconsumed entering this stage
    localparam bit LAST = (k == STAGES - 1);

    logic           src_vld;
    logic           src_brw;
    logic [SRC-1:0] src_a;
    logic [SRC-1:0] src_b;
    logic [SLICE:0] slc_d;
    logic [LOW-1:0] dif_d;
    logic           vld_q;
    logic           brw_q;
    logic [LOW-1:0] dif_q;

    if (k == 0) begin : g_src
      assign src_vld = bus.in_valid;
      assign src_brw = 1'b0;
      assign src_a   = bus.a;
      assign src_b   = bus.b;
      assign dif_d   = slc_d[SLICE-1:0];
    end else begin : g_src
      assign src_vld = g_stg[k-1].vld_q;
      assign src_brw = g_stg[k-1].brw_q;
      assign src_a   = g_stg[k-1].g_rem.rem_a_q;
      assign src_b   = g_stg[k-1].g_rem.rem_b_q;
      assign dif_d   = {slc_d[SLICE-1:0], g_stg[k-1].dif_q};
    end

    // Resolve this stage's slice; the extra top bit is the borrow out of the slice.
    assign slc_d = {1'b0, src_a[SLICE-1:0]} - {1'b0, src_b[SLICE-1:0]}
                 - {{SLICE{1'b0}}, src_brw};

    // Valid bit travels with the pipe, holds on stall; bubbles stay in place.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (advance) begin
        vld_q <= src_vld;
      end
    end

    // Slice result; the last stage skips bubbles so diff/borrow keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        brw_q <= 1'b0;
        dif_q <= '0;
      end else if (advance && (src_vld || !LAST)) begin
        brw_q <= slc_d[SLICE];
        dif_q <= dif_d;
      end
    end

    if (!LAST) begin : g_rem
      logic [SRC-SLICE-1:0] rem_a_q;
      logic [SRC-SLICE-1:0] rem_b_q;

      // Carry the not-yet-consumed upper operand slices to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (advance) begin
          rem_a_q <= src_a[SRC-1:SLICE];
          rem_b_q <= src_b[SRC-1:SLICE];
        end
      end
    end
  end

  assign out_vld       = g_stg[STAGES-1].vld_q;
  assign bus.out_valid = out_vld;
  assign bus.diff      = g_stg[STAGES-1].dif_q;
  assign bus.borrow    = g_stg[STAGES-1].brw_q;
endmodule

// File: tb/tb_subtractor_32bit_pipe.sv
`timescale 1ns/1ps
// Bench for subtractor_32bit_pipe: scoreboard of a - b results in acceptance order,
// popped and compared whenever the DUT hands a result to the consumer.
module tb_subtractor_32bit_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  subtractor_32bit_pipe_if #(.WIDTH(32)) bus ();

  subtractor_32bit_pipe #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        b;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  exp_t mon_e;
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  int   rdy_low = 0;
  bit   chk_lat = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, describing the transfers of the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("diff", bus.diff, mon_e.d);
          check("borrow", bus.borrow, mon_e.b);
          if (chk_lat) check("latency", cyc - mon_e.t, 64'd4);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        logic [32:0] m;
        m = {1'b0, bus.a} - {1'b0, bus.b};
        sb.push_back('{d: m[31:0], b: m[32], t: cyc});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the pair.
  task automatic send(input logic [31:0] av, input logic [31:0] bv);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(negedge clk);
    if (!bus.in_ready) rdy_low++;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", sb.size(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] snap_d;
  logic        snap_b;
  int          n0;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 64'd0);
    check("rst_diff", bus.diff, 64'd0);
    check("rst_borrow", bus.borrow, 64'd0);
    check("rst_in_ready", bus.in_ready, 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic, borrow ripple, equal operands and extremes.
    send(32'h0000_0005, 32'h0000_0003);
    drain();
    send(32'h0000_0000, 32'h0000_0001);
    send(32'h1000_0000, 32'h0000_0001);
    send(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    send(32'hFFFF_FFFF, 32'h0000_0000);
    send(32'h0000_0100, 32'h0000_0001);
    drain();

    // Back-to-back stream at full rate.
    out_cyc.delete();
    rdy_low = 0;
    for (int i = 0; i < 8; i++) send(32'(i) * 32'h0101_0101, 32'h0080_8080);
    drain();
    check("b2b_ready_low", rdy_low, 64'd0);
    check("b2b_count", out_cyc.size(), 64'd8);
    if (out_cyc.size() == 8) check("b2b_gapless", out_cyc[7] - out_cyc[0], 64'd7);

    // Backpressure: consumer stalls for 3 cycles mid-stream.
    chk_lat = 1'b0;
    out_cyc.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'h0300_0000 + 32'(i) * 32'h0011_2233, 32'h0123_4567);
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        snap_d = bus.diff;
        snap_b = bus.borrow;
        check("stall_valid", bus.out_valid, 64'd1);
        check("stall_in_ready", bus.in_ready, 64'd0);
        repeat (2) begin
          @(negedge clk);
          check("stall_valid_hold", bus.out_valid, 64'd1);
          check("stall_diff_hold", bus.diff, snap_d);
          check("stall_borrow_hold", bus.borrow, snap_b);
          check("stall_in_ready_hold", bus.in_ready, 64'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", out_cyc.size(), 64'd6);

    // Reset with three operations in flight.
    send(32'h0000_0010, 32'h0000_0020);
    send(32'h0000_0030, 32'h0000_0001);
    send(32'h8000_0000, 32'h7FFF_FFFF);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 64'd0);
    check("midrst_diff", bus.diff, 64'd0);
    check("midrst_borrow", bus.borrow, 64'd0);
    check("midrst_in_ready", bus.in_ready, 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = n_out;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", n_out - n0, 64'd0);

    // Random operands with bubbles and a randomly stalling consumer.
    out_cyc.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] ra;
          logic [31:0] rb;
          ra = $urandom;
          rb = (i % 5 == 0) ? ra : $urandom;
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(ra, rb);
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("rand_count", out_cyc.size(), 64'd40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end
endmodule
